// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - Gray/binary pointer helpers shared by both sides of the async FIFO.
package fifo_pkg;

    localparam int unsigned GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gray_word_t;

    // Pointer carries one extra lap bit so full and empty are distinguishable.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return int'($clog2(depth)) + 1;
    endfunction

    function automatic gray_word_t bin_to_gray(input gray_word_t value);
        return value ^ (value >> 1);
    endfunction

    // Prefix XOR by doubling shifts; upper zero bits do not disturb narrower pointers.
    function automatic gray_word_t gray_to_bin(input gray_word_t value);
        gray_word_t result;
        result = value;
        for (int shift = 1; shift < GRAY_MAX_W; shift = shift * 2) begin
            result = result ^ (result >> shift);
        end
        return result;
    endfunction

endpackage

// File: rtl/gray_synchroniser.sv
// rtl/gray_synchroniser.sv - Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_synchroniser #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    output logic [WIDTH-1:0] gray_out
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= gray_in;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign gray_out = stage_q[STAGES-1];

endmodule

// File: rtl/fifo_read_port.sv
// rtl/fifo_read_port.sv - Read-domain controller of the async FIFO with registered valid/ready output.
module fifo_read_port
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [$clog2(DEPTH):0]                write_pointer_gray,
    output logic [$clog2(DATA_WIDTH*DEPTH)-1:0]   read_address,
    input  logic [DATA_WIDTH-1:0]                 mem_read_data,
    output logic [DATA_WIDTH-1:0]                 data,
    output logic                                  valid,
    input  logic                                  ready,
    output logic [$clog2(DEPTH):0]                read_pointer_gray,
    output logic                                  empty,
    output logic [$clog2(DEPTH):0]                level
);

    localparam int PW    = $clog2(DEPTH);
    localparam int PTR_W = int'(ptr_width(DEPTH));
    localparam int AW    = $clog2(DATA_WIDTH*DEPTH);

    logic [PTR_W-1:0] wgray_sync;
    logic [PTR_W-1:0] wbin;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic             load;

    gray_synchroniser #(
        .WIDTH  (PTR_W),
        .STAGES (SYNC_STAGES)
    ) u_wptr_sync (
        .clk      (clk),
        .reset    (reset),
        .gray_in  (write_pointer_gray),
        .gray_out (wgray_sync)
    );

    assign wbin      = PTR_W'(gray_to_bin(gray_word_t'(wgray_sync)));
    assign rbin_next = rbin + PTR_W'(1);

    // Lap bit takes part in the compare, so a full memory never looks empty.
    assign empty        = (rbin == wbin);
    assign level        = wbin - rbin;
    assign read_address = AW'(rbin[PW-1:0]) * AW'(DATA_WIDTH);

    // Refill the output register whenever it is free or being drained this cycle.
    assign load = !empty && (!valid || ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rbin              <= '0;
            read_pointer_gray <= '0;
            data              <= '0;
            valid             <= 1'b0;
        end else if (load) begin
            data              <= mem_read_data;
            valid             <= 1'b1;
            rbin              <= rbin_next;
            read_pointer_gray <= PTR_W'(bin_to_gray(gray_word_t'(rbin_next)));
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_read_port.sv
// tb/tb_fifo_read_port.sv - Directed and randomised checks of fifo_read_port against a scoreboard.
module tb_fifo_read_port;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int PW    = 3;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW:0]   write_pointer_gray;
    logic [AW-1:0] read_address;
    logic [DW-1:0] mem_read_data;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [PW:0]   read_pointer_gray;
    logic          empty;
    logic [PW:0]   level;

    always #5 clk = ~clk;

    fifo_read_port #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .write_pointer_gray (write_pointer_gray),
        .read_address       (read_address),
        .mem_read_data      (mem_read_data),
        .data               (data),
        .valid              (valid),
        .ready              (ready),
        .read_pointer_gray  (read_pointer_gray),
        .empty              (empty),
        .level              (level)
    );

    logic [DW-1:0] mem [DEPTH];
    always_comb mem_read_data = mem[read_address[AW-1:3]];

    int            checks = 0;
    int            errors = 0;
    int            pops   = 0;
    int            written;
    int            pops0;
    logic [DW-1:0] exp_q [$];
    logic [PW:0]   wptr;
    logic [PW:0]   s1, s2;
    logic [PW:0]   prev_rpg;
    logic          prev_valid, prev_pop;
    bit            saw_wrap;

    function automatic logic [PW:0] g(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW:0] gb(input logic [PW:0] x);
        logic [PW:0] r;
        r[PW] = x[PW];
        for (int i = PW - 1; i >= 0; i--) r[i] = r[i+1] ^ x[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [DW-1:0] v);
        mem[wptr[PW-1:0]] = v;
        exp_q.push_back(v);
        wptr = wptr + 1'b1;
        write_pointer_gray = g(wptr);
    endtask

    function automatic bit room();
        logic [PW:0] d;
        d = wptr - gb(read_pointer_gray);
        return d < DEPTH;
    endfunction

    task automatic tick();
        logic [PW:0] wbin_m, rb, lvl_m;
        @(negedge clk);
        if (valid && ready) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) chk("sb_data", data, exp_q.pop_front());
            pops++;
        end
        if (prev_valid && !prev_pop) chk("valid_hold", valid, 1);
        chk("rpg_onebit", 32'($countones(read_pointer_gray ^ prev_rpg) <= 1), 1);
        wbin_m = gb(s2);
        rb     = gb(read_pointer_gray);
        lvl_m  = wbin_m - rb;
        chk("level_model", level, lvl_m);
        chk("empty_model", empty, wbin_m == rb);
        if (gb(prev_rpg) == 4'd15 && rb == 4'd0) saw_wrap = 1'b1;
        prev_valid = valid;
        prev_pop   = valid && ready;
        prev_rpg   = read_pointer_gray;
        @(posedge clk);
        s2 = s1;
        s1 = write_pointer_gray;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        ready = 1'b0;
        wptr = '0;
        write_pointer_gray = '0;
        exp_q.delete();
        s1 = '0;
        s2 = '0;
        prev_valid = 1'b0;
        prev_pop = 1'b0;
        prev_rpg = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // Reset values while held in reset
        do_reset();
        chk("rst_empty", empty, 1);
        chk("rst_valid", valid, 0);
        chk("rst_level", level, 0);
        chk("rst_addr", read_address, 0);
        chk("rst_rpg", read_pointer_gray, 0);
        reset = 1'b1;
        tick();
        chk("idle_empty", empty, 1);

        // Single entry: latency and pop
        ready = 1'b1;
        push_word(8'hA5);
        tick();
        chk("t2_empty_e1", empty, 1);
        tick();
        chk("t2_empty_e2", empty, 0);
        chk("t2_valid_e2", valid, 0);
        chk("t2_level_e2", level, 1);
        tick();
        chk("t2_valid_e3", valid, 1);
        chk("t2_data_e3", data, 8'hA5);
        chk("t2_rpg_e3", read_pointer_gray, 1);
        tick();
        chk("t2_valid_pop", valid, 0);
        chk("t2_empty_pop", empty, 1);
        chk("t2_data_hold", data, 8'hA5);

        // Full memory with consumer stalled
        do_reset();
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_word(8'(8'h30 + i * 7));
        chk("t3_wpg_full", write_pointer_gray, 4'hC);
        tick();
        tick();
        chk("t3_level_full", level, 8);
        chk("t3_valid_e2", valid, 0);
        tick();
        chk("t3_valid_load", valid, 1);
        chk("t3_data_load", data, 8'h30);
        chk("t3_level_load", level, 7);
        tick();
        tick();
        chk("t3_valid_stall", valid, 1);
        chk("t3_level_stall", level, 7);
        chk("t3_rpg_stall", read_pointer_gray, 4'(g(4'd1)));
        chk("t3_data_stall", data, 8'h30);

        // Release the consumer: back-to-back beats, address walk
        chk("t4_addr_1", read_address, 8);
        ready = 1'b1;
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            chk("t4_valid_beat", valid, 1);
            chk("t4_addr", read_address, ((i + 1) % DEPTH) * DW);
        end
        chk("t4_empty_end", empty, 1);
        tick();
        chk("t4_valid_end", valid, 0);
        chk("t4_drained", exp_q.size(), 0);

        // Stream across the lap boundary
        written = 0;
        saw_wrap = 1'b0;
        for (int c = 0; c < 300 && (written < 20 || exp_q.size() != 0); c++) begin
            if (written < 20 && room()) begin
                push_word(8'(8'h80 + written));
                written++;
            end
            tick();
        end
        chk("t5_drained", exp_q.size(), 0);
        chk("t5_written", written, 20);
        chk("t5_lap_wrap", 32'(saw_wrap), 1);

        // Random back-pressure with a slow producer
        for (int c = 0; c < 90; c++) begin
            ready = 1'($urandom_range(0, 1));
            if (c % 3 == 0 && room()) push_word(8'($urandom_range(0, 255)));
            tick();
        end
        ready = 1'b1;
        for (int c = 0; c < 60 && exp_q.size() != 0; c++) tick();
        chk("t6_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a stream
        for (int i = 0; i < 6; i++) push_word(8'(8'h50 + i));
        pops0 = pops;
        for (int c = 0; c < 40 && (pops - pops0) < 3; c++) tick();
        chk("t1_three_reads", pops - pops0, 3);
        reset = 1'b0;
        #1;
        chk("mid_empty", empty, 1);
        chk("mid_valid", valid, 0);
        chk("mid_level", level, 0);
        chk("mid_addr", read_address, 0);
        chk("mid_rpg", read_pointer_gray, 0);
        chk("mid_data", data, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_read_port.md
Name: fifo_read_port

Overview:
- Read-side controller of the asynchronous FIFO. It is the consumer end of the write-side pointer/address counter.
- Runs entirely in the read clock domain:
  - synchronises the write side's Gray-coded pointer;
  - derives empty and occupancy;
  - drives the memory read address and presents data through a registered valid/ready output stage;
  - publishes its own Gray read pointer back to the write side.

Parameters:
- DATA_WIDTH, 8: bits per FIFO entry.
- DEPTH, 8: entries in the FIFO memory. Must be a power of two and at least 2.
- SYNC_STAGES, 2: flop stages in the write-pointer synchroniser. Must be at least 2.

Ports:
(PW = $clog2(DEPTH))
- clk  in  1: read-domain clock.
- reset  in  1: asynchronous, active-low reset.
- write_pointer_gray  in  PW+1: write pointer from the write domain, Gray-coded, including the lap bit. Not yet synchronised.
- read_address  out  $clog2(DATA_WIDTH*DEPTH): bit offset of the current read entry in flat memory. Equals (read pointer mod DEPTH)*DATA_WIDTH.
- mem_read_data  in  DATA_WIDTH: memory word at read_address. The memory read is combinational, same cycle.
- data  out  DATA_WIDTH: output data.
- valid  out  1: data holds an entry.
- ready  in  1: consumer accepts data this cycle.
- read_pointer_gray  out  PW+1: registered Gray read pointer, sent to the write domain.
- empty  out  1: no entries remain in memory, as seen through the synchroniser.
- level  out  PW+1: entries in memory as seen, excluding the output register.

Behaviour:
- Reset (reset low, asynchronous): all of the following clear to 0:
  - synchroniser flops, read pointer, read_address, read_pointer_gray;
  - data, valid, level.
  - empty=1.
- Reset mid-operation discards the held entry and all pointer state. No partial handshake survives.
- Synchroniser: write_pointer_gray passes through SYNC_STAGES flops, then Gray→binary gives wbin.
- Read pointer rbin: PW+1 bits, binary, wraps modulo 2^(PW+1). The lap bit distinguishes full from empty.
- Derived signals:
  - read_address = rbin[PW-1:0]*DATA_WIDTH. It wraps from DATA_WIDTH*(DEPTH-1) to 0.
  - empty = (rbin == wbin), combinational from registers.
  - level = wbin - rbin, modulo 2^(PW+1). Range 0..DEPTH.
- Load condition: load = !empty && (!valid || ready).
- On load, at the next edge:
  - data <= mem_read_data;
  - valid <= 1;
  - rbin <= rbin+1;
  - read_pointer_gray <= gray(rbin+1).
- When valid && ready && empty: valid <= 0 and data holds its last value.
- With valid && !ready: data, valid and rbin hold.
- Throughput: one entry per cycle while not empty and ready is held high. There are no bubbles when memory stays non-empty.
- Latency:
  - a write_pointer_gray change appears in wbin and empty after SYNC_STAGES edges;
  - valid rises one edge later, SYNC_STAGES+1 in total.
- read_pointer_gray changes at most one bit per edge and is driven directly from a register, with no combinational glitch.
- Simultaneous events:
  - consumer pop and memory refill in the same cycle give a back-to-back load;
  - a new write pointer arriving while valid && !ready only updates level/empty.
- Wrap-around: after 2^(PW+1) reads, rbin returns to 0. Lap-bit comparison keeps empty correct.
- The block never advances rbin past wbin.

Decomposition:
- Shared package fifo_pkg holds:
  - function bin_to_gray(value);
  - function gray_to_bin(value);
  - localparam-style helper for the pointer width, $clog2(DEPTH)+1.
  - The write-side controller reuses the same package.
- Sub-module gray_synchroniser, parameterised WIDTH and STAGES, with async active-low reset to 0. It is reused by the write side for the read pointer.
- The read pointer counter is internal to this block because it needs the lap bit.

Test Plan:
1. Reset with write_pointer_gray=0 → empty=1, valid=0, level=0, read_address=0, read_pointer_gray=0. Assert reset mid-stream after 3 reads → all of these return to reset values immediately, without waiting for a clock edge.
2. Drive write_pointer_gray=gray(1)=1, ready=1, memory word 0=0xA5 → empty falls after 2 edges. valid=1 and data=0xA5 on edge 3. read_pointer_gray=1, then valid=0 after the pop.
3. write_pointer_gray=gray(8)=0xC, DEPTH=8, ready=0 → level=8. One entry loads into data and level becomes 7. valid stays high and rbin holds while ready=0.
4. Same setup, then ready=1 → 8 consecutive valid beats with data matching words 0..7. read_address sequence 0,8,...,56. empty=1 after the 8th load.
5. Stream 20 entries with writes steered across the lap boundary → rbin passes 15→0 (lap bit toggles). Data order is preserved and empty never asserts falsely. read_pointer_gray changes one bit per step.
6. Random ready toggling with the write pointer advanced 1 per 3 cycles → no lost or duplicated entries (scoreboard), and valid never drops without a pop.
